// File: rtl/ui_control_debounced_pkg.sv
// Shared types and field indices for the UI front-end.
package ui_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE   = 2'd0,
    BTN_DELAY  = 2'd1,
    BTN_REPEAT = 2'd2
  } btn_state_t;

  localparam int unsigned SW_W = 10;

  // Slide-switch field positions
  localparam int unsigned SW_SETHMS_LO = 0;
  localparam int unsigned SW_SET       = 2;
  localparam int unsigned SW_SRC_LO    = 4;
  localparam int unsigned SW_MINSEC    = 7;
  localparam int unsigned SW_ON        = 8;
  localparam int unsigned SW_EN_DISP   = 9;

  // Push-button positions
  localparam int unsigned BTN_UP   = 0;
  localparam int unsigned BTN_DOWN = 1;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ui_control_debounced_debounce.sv
// Two-flop synchroniser plus stability counter for one raw input bit.
module ui_debounce
  import ui_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter bit          INVERT       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYC);

  logic          s1;
  logic          s2;
  logic          level;
  logic [CW-1:0] cnt;

  // Synchroniser flops idle at the raw "inactive" level so reset looks released
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= INVERT;
      s2 <= INVERT;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Polarity normalised after the synchroniser
  assign level = s2 ^ INVERT;

  // Accept a new level only after it differs from the current one long enough
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (level == stable) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
      stable <= level;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ui_control_debounced.sv
// Switch/button front-end: debounce, field decode, step pulses with auto-repeat, LEDs.
module ui_control_debounced
  import ui_pkg::*;
#(
  parameter int unsigned N_BUTTONS         = 4,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b1,
  parameter int unsigned DEBOUNCE_CYC      = 500000,
  parameter int unsigned REPEAT_DELAY_CYC  = 25000000,
  parameter int unsigned REPEAT_PERIOD_CYC = 5000000,
  parameter int unsigned BLINK_HALF_CYC    = 12500000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           sec,
  input  logic [N_BUTTONS-1:0] button,
  input  logic [9:0]           sw,
  output logic                 on,
  output logic                 set,
  output logic                 min_or_sec,
  output logic [1:0]           source_select,
  output logic                 enable_display,
  output logic [1:0]           sethms,
  output logic [1:0]           up_down,
  output logic [N_BUTTONS-1:0] btn_pulse,
  output logic [9:0]           ledr,
  output logic [7:0]           ledg
);

  localparam int unsigned TMAX = (REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ?
                                 REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC;
  localparam int unsigned TW   = cnt_width(TMAX);
  localparam int unsigned BW   = cnt_width(BLINK_HALF_CYC);

  logic [SW_W-1:0]      sw_deb;
  logic [N_BUTTONS-1:0] btn_deb;
  logic [N_BUTTONS-1:0] btn_q;
  logic [N_BUTTONS-1:0] pulse;
  btn_state_t           state [N_BUTTONS];
  logic [TW-1:0]        timer [N_BUTTONS];
  logic                 conflict;
  logic [BW-1:0]        blink_cnt;
  logic                 blink;
  logic [5:0]           sec_q;

  // One debouncer per switch and per button
  for (genvar g = 0; g < SW_W; g++) begin : g_sw
    ui_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .INVERT(1'b0)) u_deb (
      .clk(clk), .reset(reset), .raw(sw[g]), .stable(sw_deb[g])
    );
  end

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_btn
    ui_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .INVERT(BUTTON_ACTIVE_LOW)) u_deb (
      .clk(clk), .reset(reset), .raw(button[g]), .stable(btn_deb[g])
    );
  end

  assign sethms         = sw_deb[SW_SETHMS_LO +: 2];
  assign set            = sw_deb[SW_SET];
  assign source_select  = sw_deb[SW_SRC_LO +: 2];
  assign min_or_sec     = sw_deb[SW_MINSEC];
  assign on             = sw_deb[SW_ON];
  assign enable_display = sw_deb[SW_EN_DISP];
  assign ledr           = sw_deb;

  assign conflict = btn_deb[BTN_UP] & btn_deb[BTN_DOWN];

  // Per-button press/auto-repeat FSM; up and down are held idle while both are pressed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q <= '0;
      pulse <= '0;
      for (int unsigned i = 0; i < N_BUTTONS; i++) begin
        state[i] <= BTN_IDLE;
        timer[i] <= '0;
      end
    end else begin
      btn_q <= btn_deb;
      for (int unsigned i = 0; i < N_BUTTONS; i++) begin
        pulse[i] <= 1'b0;
        if (!btn_deb[i] || (conflict && ((i == BTN_UP) || (i == BTN_DOWN)))) begin
          state[i] <= BTN_IDLE;
          timer[i] <= '0;
        end else begin
          case (state[i])
            BTN_IDLE: begin
              if (!btn_q[i]) begin
                pulse[i] <= 1'b1;
                timer[i] <= TW'(REPEAT_DELAY_CYC - 1);
                state[i] <= BTN_DELAY;
              end
            end
            BTN_DELAY, BTN_REPEAT: begin
              if (timer[i] == '0) begin
                pulse[i] <= 1'b1;
                timer[i] <= TW'(REPEAT_PERIOD_CYC - 1);
                state[i] <= BTN_REPEAT;
              end else begin
                timer[i] <= timer[i] - TW'(1);
              end
            end
            default: begin
              state[i] <= BTN_IDLE;
              timer[i] <= '0;
            end
          endcase
        end
      end
    end
  end

  assign btn_pulse = pulse;
  assign up_down   = pulse[1:0] & {2{sw_deb[SW_SET] & ~conflict}};

  // Set-mode blink: phase restarts each time set rises
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (!sw_deb[SW_SET]) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_HALF_CYC - 1)) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Seconds image for the green LEDs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sec_q <= '0;
    else       sec_q <= sec;
  end

  assign ledg = {blink & sw_deb[SW_SET], sw_deb[SW_ON], sec_q};

endmodule

// File: tb/tb_ui_control_debounced.sv
// Scoreboard bench: a cycle-level reference model predicts every output cycle.
module tb_ui_control_debounced;

  localparam int NB = 4;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int BH = 5;
  localparam int NI = 10 + NB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    sec = '0;
  logic [NB-1:0] button = '1;
  logic [9:0]    sw = '0;
  logic          on, set, min_or_sec, enable_display;
  logic [1:0]    source_select, sethms, up_down;
  logic [NB-1:0] btn_pulse;
  logic [9:0]    ledr;
  logic [7:0]    ledg;

  ui_control_debounced #(
    .N_BUTTONS(NB), .BUTTON_ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(D),
    .REPEAT_DELAY_CYC(RD), .REPEAT_PERIOD_CYC(RP), .BLINK_HALF_CYC(BH)
  ) dut (
    .clk(clk), .reset(reset), .sec(sec), .button(button), .sw(sw),
    .on(on), .set(set), .min_or_sec(min_or_sec), .source_select(source_select),
    .enable_display(enable_display), .sethms(sethms), .up_down(up_down),
    .btn_pulse(btn_pulse), .ledr(ledr), .ledg(ledg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          on;
    logic          set;
    logic          min_or_sec;
    logic [1:0]    source_select;
    logic          enable_display;
    logic [1:0]    sethms;
    logic [1:0]    up_down;
    logic [NB-1:0] btn_pulse;
    logic [9:0]    ledr;
    logic [7:0]    ledg;
  } obs_t;

  obs_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   dut_cyc = 0;
  int   base = 0;
  int   ud_log[$];
  int   bp_log[$];

  function automatic obs_t dut_obs();
    obs_t o;
    o = '{on, set, min_or_sec, source_select, enable_display, sethms,
          up_down, btn_pulse, ledr, ledg};
    return o;
  endfunction

  // ---------------- reference model ----------------
  // A level is accepted once D consecutive synchronised samples (raw delayed
  // by two clocks) all disagree with the accepted level.
  logic [NI-1:0] hist[$];
  logic [NI-1:0] deb_cur, deb_old, smp;
  logic [NB-1:0] p;
  bit            armed[NB];
  int            nxt[NB];
  int            mcyc = 0;
  int            set_t = 0;
  logic          set_prev;
  logic          conf, held, all_diff, blink_e;
  obs_t          m_e;

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < D + 2; k++) hist.push_back('0);
    deb_cur  = '0;
    deb_old  = '0;
    set_prev = 1'b0;
    for (int i = 0; i < NB; i++) begin
      armed[i] = 1'b0;
      nxt[i]   = 0;
    end
  endtask

  initial model_reset();

  always @(posedge clk) begin
    mcyc++;
    if (reset) begin
      model_reset();
      m_e = '0;
    end else begin
      smp = {~button, sw};
      hist.push_back(smp);
      if (hist.size() > D + 2) hist.delete(0);
      // pulses decided from the accepted levels of the previous cycle
      conf = deb_cur[10] & deb_cur[11];
      for (int i = 0; i < NB; i++) begin
        held = deb_cur[10 + i];
        p[i] = 1'b0;
        if (!held || (conf && i < 2)) begin
          armed[i] = 1'b0;
        end else if (!armed[i]) begin
          if (!deb_old[10 + i]) begin
            p[i] = 1'b1;
            armed[i] = 1'b1;
            nxt[i] = mcyc + RD;
          end
        end else if (mcyc == nxt[i]) begin
          p[i] = 1'b1;
          nxt[i] = mcyc + RP;
        end
      end
      deb_old = deb_cur;
      for (int b = 0; b < NI; b++) begin
        all_diff = 1'b1;
        for (int k = 0; k < D; k++) if (hist[k][b] == deb_cur[b]) all_diff = 1'b0;
        if (all_diff) deb_cur[b] = ~deb_cur[b];
      end
      if (deb_cur[2] && !set_prev) set_t = mcyc;
      set_prev = deb_cur[2];
      blink_e = deb_cur[2] ? 1'(((mcyc - set_t) / BH) % 2) : 1'b0;
      m_e.on             = deb_cur[8];
      m_e.set            = deb_cur[2];
      m_e.min_or_sec     = deb_cur[7];
      m_e.source_select  = deb_cur[5:4];
      m_e.enable_display = deb_cur[9];
      m_e.sethms         = deb_cur[1:0];
      m_e.up_down        = p[1:0] & {2{deb_cur[2] & ~(deb_cur[10] & deb_cur[11])}};
      m_e.btn_pulse      = p;
      m_e.ledr           = deb_cur[9:0];
      m_e.ledg           = {blink_e, deb_cur[8], sec};
    end
    exp_q.push_back(m_e);
  end

  // ---------------- monitor ----------------
  obs_t mon_e, mon_a;
  always @(posedge clk) begin
    #1;
    dut_cyc++;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL scoreboard_empty cyc=%0d", dut_cyc);
    end else begin
      mon_e = exp_q.pop_front();
      mon_a = dut_obs();
      if (mon_a !== mon_e) begin
        mismatched++;
        $display("FAIL cycle_outputs cyc=%0d actual=%h required=%h", dut_cyc, mon_a, mon_e);
      end
    end
    if (up_down != 2'b00) ud_log.push_back(dut_cyc);
    if (btn_pulse[0])     bp_log.push_back(dut_cyc);
  end

  // ---------------- directed checks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_int(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  int exp4[4] = '{7, 27, 35, 43};
  obs_t a0;

  initial begin
    reset = 1'b1;
    tick(3);
    reset = 1'b0;

    sw[8] = 1'b1; tick(10);
    sw[2] = 1'b1; tick(3); sw[2] = 1'b0; tick(10);

    // Held up button in set mode: first pulse plus repeats, none after release
    sw[2] = 1'b1; tick(12);
    ud_log.delete(); base = dut_cyc;
    button[0] = 1'b0; tick(44); button[0] = 1'b1; tick(15);
    check_int("up_hold_count", ud_log.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < ud_log.size()) check_int("up_hold_cycle", ud_log[k] - base, exp4[k]);

    // Set off: btn_pulse still fires, up_down stays quiet
    sw[2] = 1'b0; tick(12);
    ud_log.delete(); bp_log.delete(); base = dut_cyc;
    button[0] = 1'b0; tick(12); button[0] = 1'b1; tick(10);
    check_int("nset_pulse_count", bp_log.size(), 1);
    if (bp_log.size() > 0) check_int("nset_pulse_cycle", bp_log[0] - base, 7);
    check_int("nset_up_down_count", ud_log.size(), 0);

    // Both up and down held, then one released: no step pulses at all
    sw[2] = 1'b1; tick(12);
    ud_log.delete();
    button[1:0] = 2'b00; tick(40); button[1] = 1'b1; tick(30); button[0] = 1'b1; tick(10);
    check_int("conflict_up_down_count", ud_log.size(), 0);

    // Blink restart
    sw[2] = 1'b0; tick(12); sw[2] = 1'b1; tick(30); sw[2] = 1'b0; tick(10);

    // Async reset while repeating, button held through it
    sw[2] = 1'b1; tick(12);
    button[0] = 1'b0; tick(32);
    #2 reset = 1'b1;
    #1 a0 = dut_obs();
    compared++;
    if (a0 !== '0) begin
      mismatched++;
      $display("FAIL async_reset actual=%h required=0", a0);
    end
    tick(2);
    reset = 1'b0; bp_log.delete(); base = dut_cyc;
    tick(12);
    check_int("held_through_reset_count_min", (bp_log.size() > 0) ? 1 : 0, 1);
    if (bp_log.size() > 0) check_int("held_through_reset_cycle", bp_log[0] - base, 7);
    button[0] = 1'b1; tick(10);

    // Random traffic against the model
    repeat (700) begin
      sec = 6'($urandom);
      for (int b = 0; b < 10; b++) if ($urandom_range(0, 23) == 0) sw[b] = ~sw[b];
      for (int b = 0; b < NB; b++) if ($urandom_range(0, 11) == 0) button[b] = ~button[b];
      tick(1);
    end
    button = '1; tick(20);
    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout time=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
